// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder: default widths, the
// default wait-state count and the FSM/direction types.
package cpu_mem_pkg;

    localparam int WORD_W_DEFAULT      = 32;
    localparam int ADDR_W_DEFAULT      = 9;
    localparam int WAIT_STATES_DEFAULT = 2;
    localparam int WAIT_CNT_W          = 4;

    // Binary encoding of the responder FSM.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_ACK    = 2'b11
    } state_t;

    // Direction of the latched request.
    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: write-enable, registered (read-first) output.
module mem_array #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Write on enable and register the addressed word every cycle.
    // NOTE: the array is deliberately not reset so it maps onto block RAM;
    // its contents are undefined until written and survive Clear.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: accepts one read or write request from the datapath,
// waits WAIT_STATES cycles, performs the access on mem_array and completes
// with a four-phase Done handshake. Illegal requests (Read and Write both
// high) are rejected with a one-cycle Err pulse.
module memory_responder
    import cpu_mem_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEFAULT,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int WAIT_STATES = WAIT_STATES_DEFAULT
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [WORD_W-1:0] MDRout,
    output logic [WORD_W-1:0] Mdatain,
    output logic              Done,
    output logic              Busy,
    output logic              Err
);

    // Last count value in WAIT; unused when WAIT_STATES is 0.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0]       addr_q;
    logic [WORD_W-1:0]       data_q;
    dir_t                    dir_q;
    logic [WORD_W-1:0]       ram_rdata;
    logic                    ram_we;

    // The RAM only ever sees the latched request, so bus changes during
    // WAIT/ACCESS cannot disturb the access; it writes only in ACCESS.
    assign ram_we = (state == ST_ACCESS) && (dir_q == DIR_WRITE);

    mem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (Clock),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // Request FSM with wait counter, request latches and registered outputs.
    // NOTE: every state register uses <= so all of them update from the
    // same pre-edge values; blocking here would create ordering races.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            dir_q    <= DIR_READ;
            Mdatain  <= '0;
            Done     <= 1'b0;
            Busy     <= 1'b0;
            Err      <= 1'b0;
        end else begin
            Err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Read && Write) begin
                        Err <= 1'b1;
                    end else if (Read || Write) begin
                        addr_q   <= Address;
                        data_q   <= MDRout;
                        dir_q    <= Write ? DIR_WRITE : DIR_READ;
                        wait_cnt <= '0;
                        Busy     <= 1'b1;
                        state    <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    // First ACK cycle: RAM output is valid, raise Done.
                    // Afterwards wait for both strobes low to finish.
                    if (!Done) begin
                        Done <= 1'b1;
                        if (dir_q == DIR_READ) begin
                            Mdatain <= ram_rdata;
                        end
                    end else if (!Read && !Write) begin
                        Done  <= 1'b0;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
